// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one single-port data memory between two requesters. Requester 0
// (core load/store) has priority. Requester 1 (loader/debug) is force-granted
// once it has waited STARVE_LIMIT consecutive cycles. Synchronous read data is
// routed back to the requester that issued the read through a one-deep
// owner pipeline.
//
// Ports:
//   clk, reset (async, active-low)
//   r{0,1}_valid/we/addr/wdata  : request from each requester
//   r{0,1}_ready                : request accepted this cycle
//   r{0,1}_rvalid/rdata         : read response, one cycle after the grant
//   mem_en/we/addr/wdata        : memory port, muxed from the winner
//   mem_rdata                   : memory read data, one cycle after mem_en&!mem_we
//   starved                     : requester 1 is being force-granted
//
// Optional build macro DMEM_ARB_STATS_EN adds grant0_cnt, grant1_cnt and
// conflict_cnt (32-bit wrapping event counters).
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_valid,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ready,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ready,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          starved
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   grant0_cnt,
  output logic [31:0]   grant1_cnt,
  output logic [31:0]   conflict_cnt
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic       force_r1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       rd_vld_q, rd_vld_d;
  logic       rd_id_q, rd_id_d;

  // Arbitration and memory port. Everything combinational is qualified by
  // reset so the port is fully quiet while reset is held.
  always_comb begin
    force_r1  = reset && r1_valid && (starve_cnt_q >= LIMIT);
    gnt1      = force_r1 || (reset && r1_valid && !r0_valid);
    gnt0      = reset && r0_valid && !force_r1;
    starved   = force_r1;
    r0_ready  = gnt0;
    r1_ready  = gnt1;
    mem_en    = gnt0 || gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = r0_we;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (gnt1) begin
      mem_we    = r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  // Next-state: read owner pipeline and requester-1 wait counter.
  always_comb begin
    rd_vld_d = mem_en && !mem_we;
    rd_id_d  = gnt1;
    if (!r1_valid || gnt1) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != 8'hFF) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Stage boundary: grant -> read response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_q     <= 1'b0;
      rd_id_q      <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      rd_vld_q     <= rd_vld_d;
      rd_id_q      <= rd_id_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    r0_rvalid = rd_vld_q && !rd_id_q;
    r1_rvalid = rd_vld_q && rd_id_q;
    r0_rdata  = r0_rvalid ? mem_rdata : '0;
    r1_rdata  = r1_rvalid ? mem_rdata : '0;
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] grant0_cnt_q, grant0_cnt_d;
  logic [31:0] grant1_cnt_q, grant1_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    grant0_cnt_d   = grant0_cnt_q + 32'(gnt0);
    grant1_cnt_d   = grant1_cnt_q + 32'(gnt1);
    conflict_cnt_d = conflict_cnt_q + 32'(r0_valid && r1_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant0_cnt_q   <= '0;
      grant1_cnt_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant0_cnt_q   <= grant0_cnt_d;
      grant1_cnt_q   <= grant1_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant0_cnt   = grant0_cnt_q;
  assign grant1_cnt   = grant1_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed scenarios followed by randomized traffic. A behavioural reference
// model (wait counter, pending-response list, event tallies) predicts the
// grant, the memory port and the read responses every cycle.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic          clk;
  logic          reset;
  logic          r0_valid, r0_we, r0_ready, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_we, r1_ready, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          mem_en, mem_we, starved;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   grant0_cnt, grant1_cnt, conflict_cnt;
`endif

  dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starved(starved)
`ifdef DMEM_ARB_STATS_EN
    , .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          m_wait;          // cycles requester 1 has waited so far
  int          m_resp[$];       // owner id of the read whose data arrives next cycle
  int          m_resp_now;      // owner of response visible this cycle (-1 none)
  logic        e_g0, e_g1, e_f; // predicted grants for the current cycle
  longint      m_cnt_g0, m_cnt_g1, m_cnt_cf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_resp.delete();
    m_cnt_g0 = 0;
    m_cnt_g1 = 0;
    m_cnt_cf = 0;
  endtask

  // Predict and check the current cycle (called at posedge+1).
  task automatic eval(input logic [DW-1:0] rd);
    e_f  = r1_valid && (m_wait >= LIMIT);
    e_g0 = r0_valid && !e_f;
    e_g1 = r1_valid && (e_f || !r0_valid);
    m_resp_now = (m_resp.size() > 0) ? m_resp[0] : -1;
    mem_rdata = rd;
    #3;
    check("r0_ready", r0_ready, e_g0);
    check("r1_ready", r1_ready, e_g1);
    check("starved", starved, e_f);
    check("mem_en", mem_en, e_g0 | e_g1);
    check("mem_we", mem_we, e_g0 ? r0_we : (e_g1 ? r1_we : 1'b0));
    check("mem_addr", mem_addr, e_g0 ? r0_addr : (e_g1 ? r1_addr : '0));
    check("mem_wdata", mem_wdata, e_g0 ? r0_wdata : (e_g1 ? r1_wdata : '0));
    check("r0_rvalid", r0_rvalid, m_resp_now == 0);
    check("r1_rvalid", r1_rvalid, m_resp_now == 1);
    check("r0_rdata", r0_rdata, (m_resp_now == 0) ? rd : '0);
    check("r1_rdata", r1_rdata, (m_resp_now == 1) ? rd : '0);
  endtask

  // Advance one clock and update the model with what was granted.
  task automatic adv();
    @(posedge clk);
    #1;
    m_resp.delete();
    if (e_g0 && !r0_we) m_resp.push_back(0);
    if (e_g1 && !r1_we) m_resp.push_back(1);
    if (r1_valid && !e_g1) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
    else m_wait = 0;
    m_cnt_g0 += e_g0;
    m_cnt_g1 += e_g1;
    m_cnt_cf += (r0_valid && r1_valid);
`ifdef DMEM_ARB_STATS_EN
    check("grant0_cnt", grant0_cnt, 32'(m_cnt_g0));
    check("grant1_cnt", grant1_cnt, 32'(m_cnt_g1));
    check("conflict_cnt", conflict_cnt, 32'(m_cnt_cf));
`endif
  endtask

  task automatic req0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic req1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".port"}, {r0_ready, r0_rvalid, r1_ready, r1_rvalid, mem_en, mem_we, starved}, '0);
    check({tag, ".rdata"}, {r0_rdata, r1_rdata}, '0);
    check({tag, ".mem"}, {mem_addr, mem_wdata}, '0);
  endtask

  initial begin
    model_reset();
    m_resp_now = -1;
    reset = 1'b0;
    mem_rdata = 32'hA5A5_5A5A;
    // Requests active during reset must still see all outputs at zero.
    req0(1'b1, 1'b0, 32'h100, 32'h1);
    req1(1'b1, 1'b1, 32'h200, 32'h2);
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    req0(1'b0, 1'b0, '0, '0);
    req1(1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    eval(32'h0); adv();

    // Single read by requester 0
    req0(1'b1, 1'b0, 32'h10, '0);
    eval(32'h0);
    check("rd.ready", r0_ready, 1'b1);
    check("rd.addr", mem_addr, 32'h10);
    adv();
    req0(1'b0, 1'b0, '0, '0);
    eval(32'hDEADBEEF);
    check("rd.rvalid", r0_rvalid, 1'b1);
    check("rd.rdata", r0_rdata, 32'hDEADBEEF);
    check("rd.r1_rvalid", r1_rvalid, 1'b0);
    adv();

    // Conflict: both write in the same cycle
    req0(1'b1, 1'b1, 32'h20, 32'h5);
    req1(1'b1, 1'b1, 32'h24, 32'h7);
    eval(32'h0);
    check("cf.addr", mem_addr, 32'h20);
    check("cf.wdata", mem_wdata, 32'h5);
    check("cf.r1_ready", r1_ready, 1'b0);
    adv();
    req0(1'b0, 1'b0, '0, '0);
    eval(32'h0);
    check("cf.r1_grant", r1_ready, 1'b1);
    check("cf.addr1", mem_addr, 32'h24);
    adv();
    req1(1'b0, 1'b0, '0, '0);

    // Starvation: requester 0 always busy
    req1(1'b1, 1'b0, 32'h40, '0);
    for (int i = 0; i < LIMIT; i++) begin
      req0(1'b1, 1'b0, 32'(i * 8), '0);
      eval($urandom());
      check("st.wait", {r1_ready, starved}, 2'b00);
      adv();
    end
    req0(1'b1, 1'b0, 32'h80, '0);
    eval($urandom());
    check("st.force", {r1_ready, starved, r0_ready}, 3'b110);
    check("st.addr", mem_addr, 32'h40);
    adv();
    req1(1'b0, 1'b0, '0, '0);
    eval($urandom());
    check("st.resume", {r0_ready, starved}, 2'b10);
    adv();
    req0(1'b0, 1'b0, '0, '0);
    eval($urandom()); adv();

    // Interleaved reads
    req0(1'b1, 1'b0, 32'h0, '0);
    eval($urandom()); adv();
    req0(1'b0, 1'b0, '0, '0);
    req1(1'b1, 1'b0, 32'h4, '0);
    eval(32'h1111_AAAA);
    check("il.A", {r0_rvalid, r1_rvalid, r0_rdata}, {2'b10, 32'h1111_AAAA});
    adv();
    req1(1'b0, 1'b0, '0, '0);
    eval(32'h2222_BBBB);
    check("il.B", {r0_rvalid, r1_rvalid, r1_rdata}, {2'b01, 32'h2222_BBBB});
    adv();

    // Reset between a read grant and its response
    req0(1'b1, 1'b0, 32'h30, '0);
    eval($urandom()); adv();
    mem_rdata = 32'hCAFE_F00D;
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    req0(1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    eval(32'hCAFE_F00D);
    check("rst_mid.no_rvalid", {r0_rvalid, r1_rvalid}, 2'b00);
    adv();

    // 3 conflict cycles then 2 solo requester-1 grants
    req1(1'b1, 1'b1, 32'h50, 32'h9);
    for (int i = 0; i < 3; i++) begin
      req0(1'b1, 1'b1, 32'(32'h60 + i * 4), 32'(i));
      eval($urandom()); adv();
    end
    req0(1'b0, 1'b0, '0, '0);
    eval($urandom()); adv();
    req1(1'b1, 1'b0, 32'h54, '0);
    eval($urandom()); adv();
    req1(1'b0, 1'b0, '0, '0);
    check("stats.conflicts", 32'(m_cnt_cf), 32'd3);
    check("stats.g1", 32'(m_cnt_g1), 32'd2);

    // Randomized traffic obeying the hold-until-ready protocol
    for (int n = 0; n < 800; n++) begin
      eval($urandom());
      adv();
      if (!r0_valid || e_g0)
        req0($urandom_range(0, 99) < 75, 1'($urandom()), $urandom(), $urandom());
      if (!r1_valid || e_g1)
        req1($urandom_range(0, 99) < 50, 1'($urandom()), $urandom(), $urandom());
    end
    req0(1'b0, 1'b0, '0, '0);
    req1(1'b0, 1'b0, '0, '0);
    eval($urandom()); adv();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: requester 0 is the core load/store path and requester 1 is the program/data loader or debug port.
- Selects one request per cycle, drives the memory port, and routes the synchronous read data back to the requester that issued the read.
- Requester 0 has priority by default. A starvation counter guarantees that requester 1 is eventually served.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, number of consecutive cycles requester 1 may wait before it is force-granted (range 1..255)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- r0_valid  input  1  requester 0 request
- r0_we  input  1  1 = write, 0 = read
- r0_addr  input  AW  byte address
- r0_wdata  input  DW  write data
- r0_ready  output  1  request accepted this cycle
- r0_rvalid  output  1  read data valid for requester 0
- r0_rdata  output  DW  read data
- r1_valid, r1_we, r1_addr, r1_wdata, r1_ready, r1_rvalid, r1_rdata: same set as requester 0, for requester 1
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid one cycle after a read strobe
- starved  output  1  high while requester 1 is being force-granted

Behaviour:
- Reset (reset=0, asynchronous):
  - Every output is 0: ready, rvalid, rdata, mem_*, starved.
  - Starvation counter and read-owner pipeline register are cleared.
- Arbitration is combinational within the cycle. A transfer completes when valid && ready.
  - Force condition: starve_cnt >= STARVE_LIMIT and r1_valid. Grant goes to requester 1 and starved=1.
  - Otherwise, if r0_valid: grant requester 0.
  - Otherwise, if r1_valid: grant requester 1.
  - Otherwise: no grant, and mem_en=0.
- Memory port:
  - mem_en=1 when any grant is made.
  - mem_we, mem_addr and mem_wdata are muxed from the winner.
  - ready is asserted only to the winner.
- Requester rules:
  - A requester holds valid and its fields stable until ready.
  - The arbiter never asserts ready to a requester whose valid is low.
- Read response:
  - A granted read records its owner in a one-deep registered pipeline (owner valid + id).
  - Next cycle: owner's rvalid=1 and rdata=mem_rdata; the other requester's rvalid=0 and rdata=0.
  - Writes produce no rvalid.
- Back-to-back: a new grant is allowed every cycle, including a read in cycle N and a read by the other requester in cycle N+1. Responses stay correctly ordered by the pipeline.
- Starvation counter (8-bit):
  - Increments each cycle r1_valid=1 and requester 1 is not granted, saturating at 255.
  - Clears on any requester 1 grant, or when r1_valid=0.
- Simultaneous events: if both are valid and no force condition holds, requester 0 wins, with no bubble.
- Force grant lasts exactly one transfer. The counter then clears and requester 0 priority resumes the following cycle.
- Reset mid-read: a pending response is discarded and no rvalid appears after reset release.
- Address and data are passed unmodified. No alignment checks; width and byte-lane handling belong to the memory.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, three extra outputs are added:
  - grant0_cnt[31:0]: granted transfers for requester 0.
  - grant1_cnt[31:0]: granted transfers for requester 1.
  - conflict_cnt[31:0]: cycles with r0_valid && r1_valid.
- All three counters wrap at 2^32, clear on reset, and are observable one cycle after the counted event.
- When undefined, the ports and counters do not exist and arbitration behaviour is identical.

Test Plan:
- Single read by requester 0:
  - Stimulus: r0 read at 0x10 with the memory returning 0xDEADBEEF.
  - Response: r0_ready the same cycle with mem_en=1, mem_addr=0x10; next cycle r0_rvalid=1, r0_rdata=0xDEADBEEF, r1_rvalid=0.
- Conflict, single cycle:
  - Stimulus: r0 write 0x5 to 0x20 and r1 write 0x7 to 0x24 in the same cycle, starve_cnt=0.
  - Response: mem_addr=0x20, mem_wdata=0x5, r0_ready=1, r1_ready=0; next cycle requester 1 is granted if r0 has dropped valid.
- Starvation:
  - Stimulus: r0_valid held high continuously while r1 reads at 0x40, STARVE_LIMIT=4.
  - Response: r1 waits 4 cycles, is granted in the 5th with starved=1, then requester 0 resumes.
- Interleaved reads:
  - Stimulus: r0 read at 0x0 in cycle N, r1 read at 0x4 in cycle N+1, memory returns A then B.
  - Response: r0_rvalid with A in N+1, r1_rvalid with B in N+2, with no crossover.
- Reset during read:
  - Stimulus: assert reset low asynchronously between a read grant and its response.
  - Response: all outputs are 0 immediately, and no rvalid appears after release.
- Stats (DMEM_ARB_STATS_EN):
  - Stimulus: 3 conflict cycles followed by 2 solo r1 grants.
  - Response: conflict_cnt=3, grant0_cnt=3, grant1_cnt=2.
